// File: rtl/hwpe_ctrl_regfile_bist.sv
// March C- BIST engine driving the BIST port of a 1R/1W regfile; one op per cycle, 10*2**ADDR_WIDTH+1 busy cycles.
// Latency: read data compared one cycle after the read op; no backpressure, start is ignored while busy.
module hwpe_ctrl_regfile_bist #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BYTE   = DATA_WIDTH/8
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [7:0]            fail_count,
    output logic                  BIST,
    output logic                  CSN_T,
    output logic                  WEN_T,
    output logic [ADDR_WIDTH-1:0] A_T,
    output logic [DATA_WIDTH-1:0] D_T,
    output logic [NUM_BYTE-1:0]   BE_T,
    input  logic [DATA_WIDTH-1:0] Q_T
);

    typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, M4, M5, DRAIN} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    state_t                  state;
    logic                    wr_phase;
    logic                    chk_vld;
    logic                    chk_exp;
    logic [ADDR_WIDTH-1:0]   chk_addr;

    state_t                  nxt_state;
    logic [ADDR_WIDTH-1:0]   nxt_addr;
    logic                    nxt_wr;
    logic                    nxt_op;
    logic                    nxt_is_wr;
    logic                    nxt_wval;
    logic                    cur_rexp;
    logic                    mismatch;

    // A_T doubles as the march address counter; wr_phase marks the write half of a r/w pair.
    always_comb begin
        nxt_state = state;
        nxt_addr  = A_T;
        nxt_wr    = 1'b0;
        unique case (state)
            IDLE: begin
                nxt_addr = '0;
                if (start) nxt_state = M0;
            end
            M0: begin
                if (A_T == ADDR_LAST) begin
                    nxt_state = M1;
                    nxt_addr  = '0;
                end else begin
                    nxt_addr = A_T + ADDR_WIDTH'(1);
                end
            end
            M1, M2: begin
                if (!wr_phase) begin
                    nxt_wr = 1'b1;
                end else if (A_T == ADDR_LAST) begin
                    nxt_state = (state == M1) ? M2 : M3;
                    nxt_addr  = (state == M1) ? '0 : ADDR_LAST;
                end else begin
                    nxt_addr = A_T + ADDR_WIDTH'(1);
                end
            end
            M3, M4: begin
                if (!wr_phase) begin
                    nxt_wr = 1'b1;
                end else if (A_T == '0) begin
                    nxt_state = (state == M3) ? M4 : M5;
                    nxt_addr  = (state == M3) ? ADDR_LAST : '0;
                end else begin
                    nxt_addr = A_T - ADDR_WIDTH'(1);
                end
            end
            M5: begin
                if (A_T == ADDR_LAST) begin
                    nxt_state = DRAIN;
                    nxt_addr  = '0;
                end else begin
                    nxt_addr = A_T + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                nxt_state = IDLE;
                nxt_addr  = '0;
            end
            default: nxt_state = IDLE;
        endcase
    end

    assign nxt_op    = (nxt_state != IDLE) && (nxt_state != DRAIN);
    assign nxt_is_wr = (nxt_state == M0) || (nxt_wr && nxt_state inside {M1, M2, M3, M4});
    assign nxt_wval  = (nxt_state == M1) || (nxt_state == M3);
    assign cur_rexp  = (state == M2) || (state == M4);
    assign mismatch  = chk_vld && (Q_T != {DATA_WIDTH{chk_exp}});

    always_ff @(posedge clk) begin
        if (clear) begin
            state      <= IDLE;
            wr_phase   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_count <= '0;
            BIST       <= 1'b0;
            CSN_T      <= 1'b1;
            WEN_T      <= 1'b1;
            A_T        <= '0;
            D_T        <= '0;
            BE_T       <= '0;
            chk_vld    <= 1'b0;
            chk_exp    <= 1'b0;
            chk_addr   <= '0;
        end else begin
            state    <= nxt_state;
            wr_phase <= nxt_wr;
            A_T      <= nxt_addr;
            busy     <= (nxt_state != IDLE);
            BIST     <= (nxt_state != IDLE);
            CSN_T    <= !nxt_op;
            WEN_T    <= !(nxt_op && nxt_is_wr);
            D_T      <= (nxt_op && nxt_is_wr) ? {DATA_WIDTH{nxt_wval}} : '0;
            BE_T     <= (nxt_op && nxt_is_wr) ? '1 : '0;

            // The read presented this cycle returns data next cycle; remember what it should be.
            chk_vld  <= busy && !CSN_T && WEN_T;
            chk_exp  <= cur_rexp;
            chk_addr <= A_T;

            if (state == IDLE && start) begin
                done       <= 1'b0;
                fail       <= 1'b0;
                fail_addr  <= '0;
                fail_count <= '0;
            end else if (mismatch) begin
                fail <= 1'b1;
                if (!fail) fail_addr <= chk_addr;
                if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
            end

            if (state == DRAIN) done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hwpe_ctrl_regfile_bist.sv
// Directed bench for hwpe_ctrl_regfile_bist with a behavioural regfile carrying per-word stuck-at masks.
module tb_hwpe_ctrl_regfile_bist;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NB = 4;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          clear;
    logic          start;
    logic          busy, done, fail, BIST, CSN_T, WEN_T;
    logic [AW-1:0] fail_addr, A_T;
    logic [7:0]    fail_count;
    logic [DW-1:0] D_T, Q_T;
    logic [NB-1:0] BE_T;

    int checks = 0;
    int errors = 0;

    hwpe_ctrl_regfile_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTE(NB)) dut (
        .clk(clk), .clear(clear), .start(start), .busy(busy), .done(done), .fail(fail),
        .fail_addr(fail_addr), .fail_count(fail_count), .BIST(BIST), .CSN_T(CSN_T),
        .WEN_T(WEN_T), .A_T(A_T), .D_T(D_T), .BE_T(BE_T), .Q_T(Q_T)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [N];
    logic [DW-1:0] sa0 [N];
    logic [DW-1:0] sa1 [N];

    always @(posedge clk) begin
        if (!CSN_T) begin
            if (!WEN_T) begin
                for (int b = 0; b < NB; b++)
                    if (BE_T[b]) mem[A_T][b*8 +: 8] <= D_T[b*8 +: 8];
            end else begin
                Q_T <= (mem[A_T] & ~sa0[A_T]) | sa1[A_T];
            end
        end
    end

    // Per-cycle trace of the last run, indexed by op cycle after start.
    logic [AW-1:0] op_a   [400];
    logic          op_csn [400];
    logic          op_wen [400];
    logic [DW-1:0] op_d   [400];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < N; i++) begin
            sa0[i] = '0;
            sa1[i] = '0;
        end
    endtask

    // Pulses start, then follows the run; optionally re-pulses start or asserts clear at a given op cycle.
    task automatic do_run(input int pulse_at, input int clear_at, output int ncyc);
        ncyc  = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (busy && ncyc < 400) begin
            op_a[ncyc]   = A_T;
            op_csn[ncyc] = CSN_T;
            op_wen[ncyc] = WEN_T;
            op_d[ncyc]   = D_T;
            start = (ncyc == pulse_at);
            clear = (ncyc == clear_at);
            ncyc++;
            @(negedge clk);
            start = 1'b0;
            if (clear) begin
                clear = 1'b0;
                return;
            end
        end
        if (ncyc >= 400) chk("run_timeout", 64'(ncyc), 64'd321);
    endtask

    typedef struct {
        string         name;
        bit            all_words;
        int            fa;
        logic [DW-1:0] fa_sa0;
        logic [DW-1:0] fa_sa1;
        int            fb;
        logic [DW-1:0] fb_sa0;
        logic [DW-1:0] fb_sa1;
        logic          exp_fail;
        logic [AW-1:0] exp_addr;
        logic [7:0]    exp_cnt;
    } vec_t;

    vec_t vecs [6];
    int   ncyc;

    initial begin
        vecs[0] = '{"ideal",     1'b0, -1, '0,           '0,           -1, '0,    '0,    1'b0, 5'd0,  8'd0};
        vecs[1] = '{"a7b3_sa0",  1'b0,  7, 32'h8,        '0,           -1, '0,    '0,    1'b1, 5'd7,  8'd2};
        vecs[2] = '{"all_sa0",   1'b1,  0, 32'hFFFFFFFF, '0,           -1, '0,    '0,    1'b1, 5'd0,  8'd64};
        vecs[3] = '{"all_sa1",   1'b1,  0, '0,           32'hFFFFFFFF, -1, '0,    '0,    1'b1, 5'd0,  8'd96};
        vecs[4] = '{"a31_sa1",   1'b0, 31, '0,           32'h80000000, -1, '0,    '0,    1'b1, 5'd31, 8'd3};
        vecs[5] = '{"a5_a9_mix", 1'b0,  5, 32'h1,        '0,            9, '0,    32'h2, 1'b1, 5'd9,  8'd5};

        for (int i = 0; i < N; i++) mem[i] = '0;
        clear_faults();
        Q_T   = '0;
        start = 1'b0;
        clear = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("rst_busy",  64'(busy),       64'd0);
        chk("rst_done",  64'(done),       64'd0);
        chk("rst_fail",  64'(fail),       64'd0);
        chk("rst_faddr", 64'(fail_addr),  64'd0);
        chk("rst_fcnt",  64'(fail_count), 64'd0);
        chk("rst_bist",  64'(BIST),       64'd0);
        chk("rst_csn_wen", 64'({CSN_T, WEN_T}), 64'b11);
        chk("rst_a_d_be",  64'({A_T, BE_T, |D_T}), 64'd0);
        start = 1'b0;
        clear = 1'b0;
        @(negedge clk);

        foreach (vecs[v]) begin
            clear_faults();
            for (int i = 0; i < N; i++) begin
                if (vecs[v].all_words || i == vecs[v].fa) begin
                    sa0[i] = vecs[v].fa_sa0;
                    sa1[i] = vecs[v].fa_sa1;
                end
                if (i == vecs[v].fb) begin
                    sa0[i] = vecs[v].fb_sa0;
                    sa1[i] = vecs[v].fb_sa1;
                end
            end
            do_run(-1, -1, ncyc);
            chk({vecs[v].name, "_busy_cycles"}, 64'(ncyc), 64'd321);
            chk({vecs[v].name, "_done"},  64'(done),       64'd1);
            chk({vecs[v].name, "_fail"},  64'(fail),       64'(vecs[v].exp_fail));
            chk({vecs[v].name, "_faddr"}, 64'(fail_addr),  64'(vecs[v].exp_addr));
            chk({vecs[v].name, "_fcnt"},  64'(fail_count), 64'(vecs[v].exp_cnt));

            if (v == 0) begin
                chk("op0_write",  64'({op_csn[0], op_wen[0], op_a[0]}), 64'({1'b0, 1'b0, 5'd0}));
                chk("op0_data",   64'(op_d[0]), 64'd0);
                chk("m1_read",    64'({op_csn[32], op_wen[32], op_a[32]}), 64'({1'b0, 1'b1, 5'd0}));
                chk("m1_write",   64'({op_csn[33], op_wen[33], op_a[33]}), 64'({1'b0, 1'b0, 5'd0}));
                chk("m1_wdata",   64'(op_d[33]), 64'hFFFFFFFF);
                chk("m3_first",   64'({op_csn[160], op_wen[160], op_a[160]}), 64'({1'b0, 1'b1, 5'd31}));
                chk("m5_last",    64'({op_csn[319], op_wen[319], op_a[319]}), 64'({1'b0, 1'b1, 5'd31}));
                chk("drain_idle", 64'({op_csn[320], op_wen[320]}), 64'b11);
            end
        end
        clear_faults();

        // Abort mid-run with clear, then a fresh run must be complete and clean.
        do_run(-1, 100, ncyc);
        chk("abort_bist",  64'(BIST),  64'd0);
        chk("abort_busy",  64'(busy),  64'd0);
        chk("abort_csn",   64'(CSN_T), 64'd1);
        chk("abort_done",  64'(done),  64'd0);
        @(negedge clk);
        do_run(-1, -1, ncyc);
        chk("post_abort_cycles", 64'(ncyc), 64'd321);
        chk("post_abort_fail",   64'(fail), 64'd0);
        chk("post_abort_done",   64'(done), 64'd1);

        // Start while busy is ignored.
        do_run(50, -1, ncyc);
        chk("start_busy_cycles", 64'(ncyc), 64'd321);
        repeat (3) @(negedge clk);
        chk("start_busy_no_rerun", 64'(busy), 64'd0);

        // Restart after a failing run clears done and fail on the next cycle.
        sa0[7] = 32'h8;
        do_run(-1, -1, ncyc);
        chk("fail_run_fail", 64'(fail), 64'd1);
        clear_faults();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_done", 64'(done),       64'd0);
        chk("restart_fail", 64'(fail),       64'd0);
        chk("restart_fcnt", 64'(fail_count), 64'd0);
        chk("restart_busy", 64'(busy),       64'd1);
        ncyc = 0;
        while (busy && ncyc < 400) begin
            ncyc++;
            @(negedge clk);
        end
        chk("restart_cycles", 64'(ncyc), 64'd321);
        chk("restart_clean",  64'(fail), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hwpe_ctrl_regfile_bist.md
HWPE_CTRL_REGFILE_BIST -- requirements
Module: hwpe_ctrl_regfile_bist

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, regfile address width; 2**ADDR_WIDTH words tested.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, regfile word width.
REQ-003 SHALL have parameter NUM_BYTE, default DATA_WIDTH/8, byte-enable width.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port clear  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  in  1  request to run the march test.
REQ-007 SHALL have port busy  out  1  test in progress.
REQ-008 SHALL have port done  out  1  test finished; held until next accepted start or clear.
REQ-009 SHALL have port fail  out  1  sticky mismatch flag.
REQ-010 SHALL have port fail_addr  out  ADDR_WIDTH  address of first mismatch.
REQ-011 SHALL have port fail_count  out  8  saturating mismatch count.
REQ-012 SHALL have port BIST  out  1  regfile BIST mux select.
REQ-013 SHALL have ports CSN_T, WEN_T  out  1 each  active-low chip select and write enable to regfile BIST port.
REQ-014 SHALL have port A_T  out  ADDR_WIDTH  test address.
REQ-015 SHALL have port D_T  out  DATA_WIDTH  test write data.
REQ-016 SHALL have port BE_T  out  NUM_BYTE  test byte enables.
REQ-017 SHALL have port Q_T  in  DATA_WIDTH  regfile read data, valid one cycle after read op.

Function
REQ-018 SHALL implement March C-: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0).
REQ-019 SHALL use 0 = all-zeros word and 1 = all-ones word.
REQ-020 SHALL issue exactly one op per cycle; read op: CSN_T=0, WEN_T=1; write op: CSN_T=0, WEN_T=0, BE_T all ones.
REQ-021 SHALL, in r/w elements, issue read then write to the same address in consecutive cycles before advancing the address.
REQ-022 SHALL start up elements at address 0 and end at 2**ADDR_WIDTH-1; down elements start at 2**ADDR_WIDTH-1 and end at 0; no address wrap within an element.
REQ-023 SHALL use FSM states IDLE, M0..M5, DRAIN; IDLE->M0 on start; Mk->Mk+1 after the last op at the element's end address; M5->DRAIN; DRAIN->IDLE.
REQ-024 SHALL, on accepting start in IDLE, clear done, fail, fail_addr and fail_count, and present the first M0 write on the next cycle.
REQ-025 SHALL ignore start while busy=1.
REQ-026 SHALL hold busy=1 and BIST=1 in M0..M5 and DRAIN, i.e. for exactly 10*2**ADDR_WIDTH+1 cycles.
REQ-027 SHALL drive CSN_T=1, WEN_T=1 in IDLE and DRAIN.
REQ-028 SHALL register the expected value and address of each read, and compare Q_T against it in the following cycle; DRAIN performs the final M5 compare.
REQ-029 SHALL, on a mismatch, set fail, capture fail_addr only if fail was 0, and increment fail_count, saturating at 255.
REQ-030 SHALL set done=1 on the DRAIN->IDLE transition.

Reset
REQ-031 SHALL, when clear=1, force next cycle: IDLE, busy=0, done=0, fail=0, fail_addr=0, fail_count=0, BIST=0, CSN_T=1, WEN_T=1, A_T=0, D_T=0, BE_T=0.
REQ-032 SHALL let clear override start and abort a running test with no further regfile ops; any pending compare is discarded.

Verification
REQ-033 SHALL pass: ideal regfile model, ADDR_WIDTH=5, start pulse -> busy high 321 cycles, done=1, fail=0, fail_count=0.
REQ-034 SHALL pass: first ops after start -> write A_T=0 D_T=0; M1 begins read A_T=0, then write A_T=0 D_T=all ones; M3 begins at A_T=31.
REQ-035 SHALL pass: bit 3 of address 7 stuck-at-0 -> fail=1, fail_addr=7, fail_count=2 (M2 and M4 reads).
REQ-036 SHALL pass: clear asserted on op cycle 100 -> next cycle BIST=0, busy=0, CSN_T=1; a fresh start then completes in 321 busy cycles with fail=0.
REQ-037 SHALL pass: start pulsed while busy -> ignored, run length unchanged; start after done -> done and fail cleared on the next cycle.
REQ-038 SHALL pass: all words stuck-at-0 -> fail_addr=0, fail_count=64 (no saturation); all words stuck-at-1 -> fail_count=96.
